sd_image_responder: RTL
=======================

# sd_image_responder

Responder end of the block-request interface used by the 1541 track loader: services `sd_rd`/`sd_wr` requests for 512-byte blocks against a byte-wide disk-image memory (SDRAM/BRAM behind a request/acknowledge port). It raises `sd_ack`, streams the block through `sd_buff_*`, and drops `sd_ack` when the block is complete. It replaces the IO-controller side in simulation and in standalone builds where the D64 image is preloaded into memory.

## Interface
Parameters:
- `MEM_AW`, 19, byte address width of the image memory; block index is `mem_addr[MEM_AW-1:9]`.
- `IMG_BLOCKS`, 342, number of valid 512-byte blocks (a D64 image of 683 sectors rounded up).

Ports:
- `clk`  in  1  system clock; everything is synchronous to it.
- `reset`  in  1  synchronous, active-high reset.
- `sd_lba`  in  32  block number of the request; sampled when the request is accepted.
- `sd_rd`  in  1  read request; held high by the initiator until `sd_ack` is seen.
- `sd_wr`  in  1  write request; same rule as `sd_rd`.
- `sd_ack`  out  1  transfer in progress; a falling edge marks completion.
- `sd_buff_addr`  out  9  byte index within the block.
- `sd_buff_dout`  out  8  read data toward the initiator.
- `sd_buff_din`  in  8  write data from the initiator's buffer (1-cycle synchronous RAM behind it).
- `sd_buff_wr`  out  1  one-cycle strobe; `sd_buff_dout` is valid at `sd_buff_addr`.
- `mem_req`  out  1  memory request; held until `mem_ack`.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `mem_addr`  out  MEM_AW  byte address.
- `mem_din`  out  8  write data.
- `mem_dout`  in  8  read data; valid in the `mem_ack` cycle.
- `mem_ack`  in  1  one-cycle completion pulse.
- `lba_err`  out  1  one-cycle pulse when an out-of-range block is requested.

## Operation
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT1, WR_SAMPLE, WR_REQ, DONE. The byte counter `cnt` is 9 bits wide.
- IDLE: when `sd_rd` is high, latch `sd_lba`, clear `cnt`, set `sd_ack`, and go to RD_REQ. Otherwise, when `sd_wr` is high, do the same and go to WR_ADDR. If both are high, read wins.
- Range check: `oor = latched_lba >= IMG_BLOCKS`, evaluated on the 32-bit value. When the request is accepted with `oor` set, pulse `lba_err`.
- RD_REQ: if `oor`, skip memory and use data 0x00. Otherwise assert `mem_req` with `mem_we=0` and `mem_addr={lba[MEM_AW-10:0],cnt}`, and wait for `mem_ack`. Capture the data, then go to RD_PUT.
- RD_PUT: drive `sd_buff_addr=cnt`, `sd_buff_dout=data`, and `sd_buff_wr=1` for one cycle. If `cnt==511` go to DONE; otherwise increment `cnt` and return to RD_REQ.
- WR_ADDR → WR_WAIT1 → WR_SAMPLE: present `sd_buff_addr=cnt` and hold it through WR_SAMPLE; capture `sd_buff_din` in WR_SAMPLE.
- WR_REQ: assert `mem_req` with `mem_we=1` and `mem_din` set to the captured byte; wait for `mem_ack`. If `oor`, skip the memory access. If `cnt==511` go to DONE; otherwise increment `cnt` and go to WR_ADDR.
- DONE: clear `sd_ack` and go to IDLE.
- Request acceptance: a request is accepted in IDLE only when `sd_ack` was already low in the previous cycle. This guarantees the initiator sees at least one low cycle of `sd_ack`.
- `cnt` wraps only via DONE and never rolls over into the next block.

## Timing
- Reset values: `sd_ack=0`, `sd_buff_wr=0`, `sd_buff_addr=0`, `sd_buff_dout=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`, `lba_err=0`; state is IDLE.
- `sd_ack` rises one cycle after the request is first seen high in IDLE.
- Per-byte read cost: `mem_ack` latency + 2 cycles. For an out-of-range read: 2 cycles per byte.
- Per-byte write cost: 3 cycles + `mem_ack` latency. `sd_buff_din` is sampled exactly 2 cycles after `sd_buff_addr` changes.
- `sd_ack` falls one cycle after the last `sd_buff_wr` (read) or after the last `mem_ack` (write).
- `mem_addr`, `mem_we` and `mem_din` are stable for as long as `mem_req` is high.
- Reset mid-transfer: all outputs return to their reset values on the next edge, and the partial block is abandoned. A `mem_ack` arriving after reset while in IDLE is ignored.
- Request lines changing during a transfer are ignored until IDLE.

## Configuration
- `SD_RESP_WRITE_EN` defined: write path as described above.
- `SD_RESP_WRITE_EN` undefined: write path not compiled in (image is write-protected). A write request is still acknowledged and `sd_buff_addr` still steps 0..511 at 1 byte per cycle, so the initiator's handshake completes. No `mem_req` is issued, and `lba_err` pulses at acceptance regardless of range.

## Structure
- Package `sd_resp_pkg`: state enum `sd_resp_state_t`, `SD_BLOCK_BYTES=512`, `SD_CNT_W=9`, and the write-sample delay constant `SD_WR_SAMPLE_DLY=2`.
- Single module. The byte counter and the range check are inline; no sub-module is warranted.

## Test plan
- Read LBA 5, memory preloaded with `data[a]=a[7:0]^a[16:9]` and `mem_ack` 1 cycle after `mem_req` → 512 `sd_buff_wr` strobes with addresses 0..511, data 0x05^addr[7:0], and `sd_ack` high for 1536 cycles.
- Write LBA 2, initiator RAM holding `0xFF-addr[7:0]` → memory bytes 0x400..0x5FF equal `0xFF-(a&0xFF)`; with the macro undefined, memory is untouched and `lba_err` pulses once.
- Read LBA 342 → `lba_err` pulse, 512 bytes of 0x00, zero `mem_req` cycles.
- `sd_rd` and `sd_wr` raised in the same cycle → read transfer only; `mem_we` never set.
- Reset asserted at byte 100 of a read, then a new read of LBA 0 issued → `sd_ack` low the cycle after reset, and the new transfer starts at `sd_buff_addr=0` with correct data.
- Back-to-back: the initiator raises `sd_rd` in the cycle `sd_ack` falls → acceptance is deferred one cycle and `sd_ack` stays low for ≥1 cycle.

Source files
------------

// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the SD block-request responder.
package sd_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_WAIT1,
        WR_SAMPLE,
        WR_REQ,
        DONE
    } sd_resp_state_t;

    localparam int SD_BLOCK_BYTES   = 512;
    localparam int SD_CNT_W         = 9;
    localparam int SD_WR_SAMPLE_DLY = 2;

endpackage

// File: rtl/sd_image_responder.sv
// Responder for sd_rd/sd_wr block requests against a byte-wide image memory (write path under SD_RESP_WRITE_EN).
// Latency: sd_ack 1 cycle after request; per byte mem_ack latency + 2 (read), 3 + mem_ack latency (write).
// Backpressure: memory stalls via mem_req/mem_ack; the sd_buff side is never stalled and has no ready.
module sd_image_responder
    import sd_resp_pkg::*;
#(
    parameter int MEM_AW     = 19,
    parameter int IMG_BLOCKS = 342
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic              lba_err
);

    localparam int                  LBA_W    = MEM_AW - SD_CNT_W;
    localparam logic [SD_CNT_W-1:0] CNT_LAST = SD_CNT_W'(SD_BLOCK_BYTES - 1);

    sd_resp_state_t      state_q, state_d;
    logic [SD_CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [LBA_W-1:0]    lba_q, lba_d;
    logic                oor_q, oor_d;
    logic                ack_prev_q, ack_prev_d;
    logic                sd_ack_q, sd_ack_d;
    logic [8:0]          sd_buff_addr_q, sd_buff_addr_d;
    logic [7:0]          sd_buff_dout_q, sd_buff_dout_d;
    logic                sd_buff_wr_q, sd_buff_wr_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic                lba_err_q, lba_err_d;
    logic                req_oor;

    assign req_oor = (sd_lba >= 32'(IMG_BLOCKS));
    assign cnt_nxt = cnt_q + SD_CNT_W'(1);

`ifndef SD_RESP_WRITE_EN
    logic unused_buff_din;
    assign unused_buff_din = ^sd_buff_din;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lba_d          = lba_q;
        oor_d          = oor_q;
        ack_prev_d     = sd_ack_q;
        sd_ack_d       = sd_ack_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        sd_buff_wr_d   = 1'b0;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_din_d      = mem_din_q;
        lba_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // ack_prev_q guarantees the initiator saw sd_ack low for a full cycle
                if (!ack_prev_q && !sd_ack_q && (sd_rd || sd_wr)) begin
                    lba_d    = sd_lba[LBA_W-1:0];
                    oor_d    = req_oor;
                    cnt_d    = '0;
                    sd_ack_d = 1'b1;
                    if (sd_rd) begin
                        state_d    = RD_REQ;
                        lba_err_d  = req_oor;
                        mem_req_d  = !req_oor;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {sd_lba[LBA_W-1:0], {SD_CNT_W{1'b0}}};
                    end else begin
                        state_d = WR_ADDR;
`ifdef SD_RESP_WRITE_EN
                        lba_err_d = req_oor;
`else
                        lba_err_d = 1'b1;
`endif
                    end
                end
            end
            RD_REQ: begin
                if (oor_q || mem_ack) begin
                    sd_buff_dout_d = oor_q ? 8'h00 : mem_dout;
                    sd_buff_addr_d = cnt_q;
                    sd_buff_wr_d   = 1'b1;
                    mem_req_d      = 1'b0;
                    state_d        = RD_PUT;
                end
            end
            RD_PUT: begin
                if (cnt_q == CNT_LAST) begin
                    sd_ack_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d      = cnt_nxt;
                    mem_req_d  = !oor_q;
                    mem_addr_d = {lba_q, cnt_nxt};
                    state_d    = RD_REQ;
                end
            end
`ifdef SD_RESP_WRITE_EN
            WR_ADDR: begin
                sd_buff_addr_d = cnt_q;
                state_d        = WR_WAIT1;
            end
            WR_WAIT1: begin
                state_d = WR_SAMPLE;
            end
            WR_SAMPLE: begin
                // Initiator RAM has a 1-cycle read; data for cnt is valid now
                mem_din_d = sd_buff_din;
                state_d   = WR_REQ;
                if (!oor_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {lba_q, cnt_q};
                end
            end
            WR_REQ: begin
                if (oor_q || mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        sd_ack_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = cnt_nxt;
                        state_d = WR_ADDR;
                    end
                end
            end
`else
            WR_ADDR: begin
                // Write-protected image: walk the buffer so the initiator's handshake completes
                sd_buff_addr_d = cnt_q;
                if (cnt_q == CNT_LAST) begin
                    sd_ack_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
`endif
            DONE: begin
                sd_ack_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                sd_ack_d  = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            lba_q          <= '0;
            oor_q          <= 1'b0;
            ack_prev_q     <= 1'b0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            lba_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lba_q          <= lba_d;
            oor_q          <= oor_d;
            ack_prev_q     <= ack_prev_d;
            sd_ack_q       <= sd_ack_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            sd_buff_wr_q   <= sd_buff_wr_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            lba_err_q      <= lba_err_d;
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign lba_err      = lba_err_q;

endmodule
